// File: rtl/apb4_eg_reg_timer.sv
// Register-mapped down-counting timer with reload, W1C interrupt status and a
// synchronised external tick source.
module apb4_eg_reg_timer #(
  parameter int unsigned ADDRWIDTH = 12
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic                 read_en,
  input  logic                 write_en,
  input  logic [3:0]           byte_strobe,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  input  logic                 ext_in,
  output logic                 irq
);

  localparam int unsigned AW      = ADDRWIDTH - 2;
  localparam logic [31:0] IdValue = 32'h0A5E_0001;

  logic [AW-1:0] widx;
  logic          sel_ctrl, sel_reload, sel_value, sel_intstat, sel_id;

  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] reload_q, reload_d;
  logic [31:0] value_q, value_d;
  logic        intstat_q, intstat_d;
  logic        irq_q, irq_d;
  logic        sync1_q, sync2_q, sync3_q;

  logic ext_tick, tick, value_wr, reload_evt, w1c;
  logic unused_addr_lsb;

  assign widx            = addr[ADDRWIDTH-1:2];
  assign unused_addr_lsb = ^addr[1:0];

  assign sel_ctrl    = (widx == AW'(0));
  assign sel_reload  = (widx == AW'(1));
  assign sel_value   = (widx == AW'(2));
  assign sel_intstat = (widx == AW'(3));
  assign sel_id      = (widx == AW'(4));

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) res[8*k +: 8] = new_val[8*k +: 8];
    end
    return res;
  endfunction

  // sync2 is the synchronised level; sync3 holds its previous value for edge detect
  assign ext_tick = sync2_q & ~sync3_q;
  assign tick     = ctrl_q[0] & (ctrl_q[2] ? ext_tick : 1'b1);

  assign value_wr   = write_en & sel_value & (|byte_strobe);
  assign reload_evt = tick & ~value_wr & (value_q == 32'd0);
  assign w1c        = write_en & sel_intstat & byte_strobe[0] & wdata[0];

  always_comb begin
    ctrl_d    = ctrl_q;
    reload_d  = reload_q;
    value_d   = value_q;
    intstat_d = intstat_q;
    irq_d     = intstat_q & ctrl_q[1];

    if (write_en && sel_ctrl && byte_strobe[0]) ctrl_d = wdata[2:0];
    if (write_en && sel_reload) reload_d = merge_bytes(reload_q, wdata, byte_strobe);

    // A software load of VALUE swallows a coincident tick
    if (value_wr) begin
      value_d = merge_bytes(value_q, wdata, byte_strobe);
    end else if (tick) begin
      value_d = (value_q == 32'd0) ? reload_q : value_q - 32'd1;
    end

    if (reload_evt) begin
      intstat_d = 1'b1;
    end else if (w1c) begin
      intstat_d = 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      ctrl_q    <= 3'd0;
      reload_q  <= 32'd0;
      value_q   <= 32'd0;
      intstat_q <= 1'b0;
      irq_q     <= 1'b0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      reload_q  <= reload_d;
      value_q   <= value_d;
      intstat_q <= intstat_d;
      irq_q     <= irq_d;
      sync1_q   <= ext_in;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
    end
  end

  assign irq = irq_q;

  always_comb begin
    rdata = 32'd0;
    if (read_en) begin
      if (sel_ctrl)         rdata = {29'd0, ctrl_q};
      else if (sel_reload)  rdata = reload_q;
      else if (sel_value)   rdata = value_q;
      else if (sel_intstat) rdata = {31'd0, intstat_q};
      else if (sel_id)      rdata = IdValue;
    end
  end

endmodule
